// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared APB/UART constants and scheduler state type
package uart_pkg;

   localparam int APB_ADDR_W = 12;
   localparam int APB_DATA_W = 8;
   localparam logic [APB_ADDR_W-1:0] TX_ADDR_DEFAULT = 12'h104;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

endpackage

// File: rtl/apb_uart_tx_scheduler_if.sv
// rtl/apb_uart_tx_scheduler_if.sv - requester handshakes and APB write port of the TX scheduler
interface apb_uart_tx_scheduler_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*APB_DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          PSEL;
   logic                          PENABLE;
   logic                          PWRITE;
   logic [APB_ADDR_W-1:0]         PADDR;
   logic [APB_DATA_W-1:0]         PWDATA;
   logic                          PREADY;

   modport master (
      input  req_valid, req_data, PREADY,
      output req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_data, PREADY,
      input  req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting at ptr
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   always_comb begin
      int j;
      logic [IDX_W-1:0] jj;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // scan ptr, ptr+1, ... with wrap so the first hit is the fairest candidate
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IDX_W'(j);
         if (!any && req[jj]) begin
            any     = 1'b1;
            gnt[jj] = 1'b1;
            gnt_idx = jj;
         end
      end
   end

endmodule

// File: rtl/apb_uart_tx_scheduler.sv
// rtl/apb_uart_tx_scheduler.sv - round-robin byte scheduler issuing APB writes to the UART TX register
module apb_uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int                    NUM_REQ = 4,
   parameter logic [APB_ADDR_W-1:0] TX_ADDR = TX_ADDR_DEFAULT,
   parameter int                    TIMEOUT = 1024,
   parameter int                    IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     enable,
   apb_uart_tx_scheduler_if.master  bus,
   output logic                     busy,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t                 state_q, state_d;
   logic [APB_DATA_W-1:0]  data_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [NUM_REQ-1:0]     arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   logic                   grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (bus.req_valid),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      timeout_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && arb_any) begin
               grant   = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            // PREADY takes priority over an expiring timeout
            if (bus.PREADY) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_err = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         data_q   <= '0;
         grant_id <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            data_q   <= bus.req_data[arb_idx*APB_DATA_W +: APB_DATA_W];
            grant_id <= arb_idx;
            ptr_q    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
         end
         if (state_q == SETUP) begin
            cnt_q <= '0;
         end else if (state_q == ACCESS && !bus.PREADY) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // ready is gated by reset so an asserted PRESETn-low never shows a stray accept
   assign bus.req_ready = (grant && PRESETn) ? arb_gnt : '0;
   assign busy          = (state_q != IDLE);
   assign bus.PSEL      = busy;
   assign bus.PENABLE   = (state_q == ACCESS);
   assign bus.PWRITE    = busy;
   assign bus.PADDR     = busy ? TX_ADDR : '0;
   assign bus.PWDATA    = busy ? data_q : '0;

endmodule

// File: tb/tb_apb_uart_tx_scheduler.sv
// tb/tb_apb_uart_tx_scheduler.sv - self-checking bench for apb_uart_tx_scheduler
module tb_apb_uart_tx_scheduler;

   localparam int NUM = 4;
   localparam int TO  = 8;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        enable;
   logic        busy;
   logic [1:0]  grant_id;
   logic        timeout_err;

   apb_uart_tx_scheduler_if #(.NUM_REQ(NUM)) bus ();

   apb_uart_tx_scheduler #(
      .NUM_REQ (NUM),
      .TX_ADDR (12'h104),
      .TIMEOUT (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .enable      (enable),
      .bus         (bus),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   always #5 PCLK = ~PCLK;

   int errors = 0;
   int checks = 0;

   // stimulus variables applied at each falling edge
   logic           rst_n;
   logic           en;
   logic           pr;
   logic [NUM-1:0] v;
   logic [31:0]    d;
   logic [NUM-1:0] last_ready;

   // transaction-level model
   bit             m_active;
   int             m_acc;
   int             m_ptr;
   int             m_gid;
   logic [7:0]     m_byte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_acc    = 0;
      m_ptr    = 0;
      m_gid    = 0;
      m_byte   = 8'h00;
   endtask

   task automatic cycle();
      int             win;
      logic [NUM-1:0] e_ready;
      @(negedge PCLK);
      PRESETn       = rst_n;
      enable        = en;
      bus.PREADY    = pr;
      bus.req_valid = v;
      bus.req_data  = d;
      #1;
      if (!rst_n) model_reset();
      win     = -1;
      e_ready = '0;
      if (rst_n && !m_active && en) begin
         for (int k = 0; k < NUM; k++) begin
            if (win < 0 && v[(m_ptr + k) % NUM]) win = (m_ptr + k) % NUM;
         end
         if (win >= 0) e_ready[win] = 1'b1;
      end
      chk("req_ready",   bus.req_ready, e_ready);
      chk("PSEL",        bus.PSEL, m_active);
      chk("PENABLE",     bus.PENABLE, m_active && m_acc >= 1);
      chk("PWRITE",      bus.PWRITE, m_active);
      chk("PADDR",       bus.PADDR, m_active ? 12'h104 : 12'h000);
      chk("PWDATA",      bus.PWDATA, m_active ? m_byte : 8'h00);
      chk("busy",        busy, m_active);
      chk("grant_id",    grant_id, m_gid);
      chk("timeout_err", timeout_err, m_active && m_acc == TO && !pr);
      if (rst_n) begin
         if (!m_active) begin
            if (win >= 0) begin
               m_active = 1;
               m_acc    = 0;
               m_byte   = d[win*8 +: 8];
               m_gid    = win;
               m_ptr    = (win + 1) % NUM;
            end
         end else if (m_acc == 0) begin
            m_acc = 1;
         end else if (pr || m_acc == TO) begin
            m_active = 0;
         end else begin
            m_acc++;
         end
      end
      last_ready = e_ready;
   endtask

   initial begin
      int mode;
      model_reset();
      rst_n = 0; en = 0; pr = 0; v = '0; d = '0; last_ready = '0;
      PRESETn = 0; enable = 0; bus.PREADY = 0; bus.req_valid = '0; bus.req_data = '0;

      // single request with a literal walk through the slot
      cycle(); cycle();
      chk("reset_busy", busy, 0);
      rst_n = 1; en = 1; v = 4'b0100; d = 32'h00A5_0000; pr = 1;
      cycle();
      chk("t1_ready", bus.req_ready, 4'b0100);
      v = '0;
      cycle();
      chk("t1_setup", {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA}, {1'b1, 1'b0, 12'h104, 8'hA5});
      cycle();
      chk("t1_access", bus.PENABLE, 1);
      cycle();
      chk("t1_idle", {busy, grant_id}, {1'b0, 2'd2});

      // fairness from a fresh pointer
      rst_n = 0; cycle(); rst_n = 1;
      v = 4'hF; d = 32'h1312_1110; pr = 1;
      for (int s = 0; s < 5; s++) begin
         cycle();
         chk("t2_ready", bus.req_ready, 4'b0001 << (s % 4));
         cycle();
         chk("t2_pwdata", bus.PWDATA, 8'h10 + 8'(s % 4));
         cycle();
      end
      v = '0;

      // wait states
      v = 4'b0001; pr = 0;
      cycle();
      chk("t3_ready", bus.req_ready, 4'b0001);
      v = '0;
      cycle();
      for (int n = 0; n < 5; n++) begin
         cycle();
         chk("t3_wait", {bus.PSEL, bus.PENABLE, busy, timeout_err, bus.PWDATA}, {4'b1110, 8'h10});
      end
      pr = 1;
      cycle();
      chk("t3_done", {bus.PENABLE, timeout_err}, 2'b10);
      pr = 0;
      cycle();
      chk("t3_idle", busy, 0);

      // timeout, then PREADY on the last allowed cycle
      v = 4'b0011; d = 32'h0000_2120;
      cycle();
      chk("t4_ready_a", bus.req_ready, 4'b0010);
      v = 4'b0001;
      cycle();
      for (int n = 1; n <= TO; n++) begin
         cycle();
         chk("t4_timeout", timeout_err, n == TO);
      end
      cycle();
      chk("t4_ready_b", {bus.PSEL, bus.req_ready}, {1'b0, 4'b0001});
      v = '0;
      cycle();
      for (int n = 1; n <= TO; n++) begin
         pr = (n == TO);
         cycle();
         chk("t4_no_timeout", timeout_err, 0);
      end
      pr = 0;
      cycle();
      chk("t4_idle", busy, 0);

      // enable gating
      v = 4'b0011; pr = 1;
      cycle();
      chk("t5_ready", bus.req_ready, 4'b0010);
      v = 4'b0001;
      cycle();
      en = 0;
      cycle();
      chk("t5_complete", {bus.PSEL, bus.PENABLE}, 2'b11);
      for (int n = 0; n < 3; n++) begin
         cycle();
         chk("t5_blocked", {busy, bus.req_ready}, 5'b0);
      end
      en = 1;
      cycle();
      chk("t5_resume", bus.req_ready, 4'b0001);
      v = '0;
      cycle(); cycle();

      // asynchronous reset during ACCESS
      v = 4'hF; pr = 0;
      cycle(); cycle(); cycle();
      chk("t6_in_access", bus.PENABLE, 1);
      #1;
      rst_n = 0; PRESETn = 0;
      #1;
      chk("t6_async", {bus.PSEL, bus.PENABLE, busy, bus.req_ready}, 7'b0);
      model_reset();
      cycle();
      rst_n = 1;
      cycle();
      chk("t6_first", bus.req_ready, 4'b0001);

      // randomized traffic
      mode = 0;
      for (int it = 0; it < 3000; it++) begin
         if (it % 64 == 0) mode = $urandom_range(0, 2);
         en    = ($urandom_range(0, 9) != 0);
         rst_n = (it != 1500);
         case (mode)
            0:       pr = ($urandom_range(0, 3) != 0);
            1:       pr = 1'b0;
            default: pr = ($urandom_range(0, 4) == 0);
         endcase
         for (int i = 0; i < NUM; i++) begin
            if (last_ready[i]) begin
               if ($urandom_range(0, 1) == 0) v[i] = 1'b0;
               else d[i*8 +: 8] = 8'($urandom);
            end else if (!v[i] && $urandom_range(0, 3) == 0) begin
               v[i] = 1'b1;
               d[i*8 +: 8] = 8'($urandom);
            end
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
